// File: rtl/demultiplexor_pkg.sv
// Shared types and helpers for the TDM demultiplexor.
package demultiplexor_pkg;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} demux_state_t;

    localparam int DEMUX_N_CH_DEF = 4;
    localparam int DEMUX_W_DEF    = 8;

    // Next slot index: wraps only at n-1, so non-power-of-two frames work.
    function automatic int unsigned slot_next(input int unsigned c, input int unsigned n);
        return (c == n - 1) ? 0 : c + 1;
    endfunction

endpackage

// File: rtl/demux_slot_counter.sv
// Wrapping slot counter for the TDM demultiplexor.
// clr has priority over load1, which has priority over adv.
module demux_slot_counter
    import demultiplexor_pkg::*;
#(
    parameter int N_CH = DEMUX_N_CH_DEF
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    input  logic                    load1,
    input  logic                    clr,
    output logic [$clog2(N_CH)-1:0] cnt,
    output logic                    tc
);

    localparam int CW = $clog2(N_CH);

    // Slot index register: clear, restart at slot 1, or advance with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load1)
            cnt <= CW'(1);
        else if (adv)
            cnt <= CW'(slot_next(int'(cnt), N_CH));
    end

    assign tc = (int'(cnt) == N_CH - 1);

endmodule

// File: rtl/demultiplexor_tdm.sv
// TDM receive demultiplexor: steers a serial W-bit sample stream into
// N_CH channel registers, tracks frame alignment from the slot-0 marker
// and flags framing faults.
// Optional macro DEMUX_FRAME_BUFFER_EN: samples collect in a shadow bank
// and ch_data updates only once per complete frame.
module demultiplexor_tdm
    import demultiplexor_pkg::*;
#(
    parameter int N_CH = DEMUX_N_CH_DEF,
    parameter int W    = DEMUX_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [W-1:0]      din,
    input  logic              din_sof,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              locked
);

    localparam int CW = $clog2(N_CH);

    demux_state_t  state, state_nx;
    logic [CW-1:0] slot;
    logic          slot_tc;
    logic          cnt_adv, cnt_load1, cnt_clr;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic          fd_nx, err_nx;

    demux_slot_counter #(.N_CH(N_CH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .adv   (cnt_adv),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .cnt   (slot),
        .tc    (slot_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= HUNT;
        else
            state <= state_nx;
    end

    // Next state, counter control and write/pulse decisions for the accepted sample.
    always_comb begin
        state_nx  = state;
        cnt_adv   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        fd_nx     = 1'b0;
        err_nx    = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    // Only a frame start can acquire alignment; others drop silently.
                    if (din_sof) begin
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                        state_nx  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (din_sof) begin
                        // Early SOF restarts the frame at slot 0 and reports it.
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                        err_nx    = (slot != '0);
                    end else if (slot == '0) begin
                        // Missing SOF: alignment lost, drop sample and re-hunt.
                        err_nx   = 1'b1;
                        cnt_clr  = 1'b1;
                        state_nx = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = slot;
                        cnt_adv = 1'b1;
                        fd_nx   = slot_tc;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Frame and error pulses, one cycle each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= fd_nx;
            sync_err   <= err_nx;
        end
    end

    assign locked = (state == LOCKED);

`ifdef DEMUX_FRAME_BUFFER_EN
    logic [N_CH*W-1:0] shadow;

    // Shadow bank collects the frame; the full frame (including the final
    // sample arriving this cycle) is published on frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            ch_data  <= '0;
            ch_valid <= '0;
        end else begin
            ch_valid <= '0;
            if (err_nx)
                shadow <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (wr_en && int'(wr_idx) == k)
                    shadow[k*W +: W] <= din;
            end
            if (fd_nx) begin
                for (int k = 0; k < N_CH; k++)
                    ch_data[k*W +: W] <= (k == N_CH - 1) ? din : shadow[k*W +: W];
                ch_valid <= '1;
            end
        end
    end
`else
    // Per-slot update: the addressed channel register loads and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data  <= '0;
            ch_valid <= '0;
        end else begin
            ch_valid <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (wr_en && int'(wr_idx) == k) begin
                    ch_data[k*W +: W] <= din;
                    ch_valid[k]       <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Self-checking bench for demultiplexor_tdm: directed frames followed by
// randomized streams, compared every cycle against a frame-level model.
module tb_demultiplexor_tdm;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_valid;
    logic [W-1:0]      din;
    logic              din_sof;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              frame_done;
    logic              sync_err;
    logic              locked;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit           m_locked;
    int           m_slot;
    logic [W-1:0] m_ch [N_CH];
    logic [W-1:0] m_sh [N_CH];
    logic [N_CH-1:0] e_valid;
    logic         e_fd, e_err;

    demultiplexor_tdm #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_sof    (din_sof),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH*W-1:0] pack_model();
        logic [N_CH*W-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*W +: W] = m_ch[k];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_slot   = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_ch[k] = '0;
            m_sh[k] = '0;
        end
        e_valid = '0;
        e_fd    = 0;
        e_err   = 0;
    endtask

    // Store one sample into the model at slot k; last == completes a frame.
    task automatic model_put(input int k, input logic [W-1:0] d, input bit last);
`ifdef DEMUX_FRAME_BUFFER_EN
        m_sh[k] = d;
        if (last) begin
            for (int j = 0; j < N_CH; j++) m_ch[j] = m_sh[j];
            e_valid = '1;
        end
`else
        m_ch[k] = d;
        e_valid[k] = 1'b1;
`endif
    endtask

    task automatic model_clear_shadow();
        for (int k = 0; k < N_CH; k++) m_sh[k] = '0;
    endtask

    // Frame-level rules applied to one clock edge.
    task automatic model_step(input bit v, input bit sof, input logic [W-1:0] d);
        e_valid = '0;
        e_fd    = 0;
        e_err   = 0;
        if (!v) return;
        if (!m_locked) begin
            if (sof) begin
                model_put(0, d, 0);
                m_locked = 1;
                m_slot   = 1;
            end
        end else if (sof) begin
            if (m_slot != 0) begin
                e_err = 1;
                model_clear_shadow();
            end
            model_put(0, d, 0);
            m_slot = 1;
        end else if (m_slot == 0) begin
            e_err    = 1;
            m_locked = 0;
            model_clear_shadow();
        end else begin
            if (m_slot == N_CH - 1) begin
                e_fd = 1;
                model_put(m_slot, d, 1);
                m_slot = 0;
            end else begin
                model_put(m_slot, d, 0);
                m_slot++;
            end
        end
    endtask

    task automatic check_all();
        chk("ch_data",    ch_data,    pack_model());
        chk("ch_valid",   ch_valid,   e_valid);
        chk("frame_done", frame_done, e_fd);
        chk("sync_err",   sync_err,   e_err);
        chk("locked",     locked,     m_locked);
    endtask

    task automatic step(input bit v, input bit sof, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = v;
        din_sof   = sof;
        din       = d;
        @(posedge clk);
        model_step(v, sof, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, W'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        din       = '0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Aligned frame on consecutive cycles.
        step(1, 1, 8'hA0);
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        step(1, 0, 8'hA3);
        chk("s1_frame", ch_data, 64'hA3A2A1A0);
        chk("s1_fd", frame_done, 1);

        // Missing SOF after a complete frame.
        step(1, 0, 8'h40);
        chk("s4_err", sync_err, 1);
        chk("s4_unchanged", ch_data, 64'hA3A2A1A0);

        // Hunt discards, then acquire.
        step(1, 0, 8'h55);
        step(1, 0, 8'h66);
        chk("s2_no_err", sync_err, 0);
        step(1, 1, 8'h10);
        chk("s2_locked", locked, 1);
        step(1, 0, 8'h11);
        step(1, 0, 8'h12);
        step(1, 0, 8'h13);

        // Early SOF mid-frame.
        step(1, 1, 8'h20);
        step(1, 0, 8'h21);
        step(1, 1, 8'h30);
        chk("s3_err", sync_err, 1);
`ifndef DEMUX_FRAME_BUFFER_EN
        chk("s3_ch0", ch_data[W-1:0], 8'h30);
`endif
        step(1, 0, 8'h31);
        step(1, 0, 8'h32);
        step(1, 0, 8'h33);
        chk("s3_resume_fd", frame_done, 1);

        // Gapped frame, then reset mid-frame.
        do_reset();
        for (int s = 0; s < N_CH; s++) begin
            step(1, s == 0, 8'hB0 + 8'(s));
            idle(3);
        end
        chk("s5_frame", ch_data, 64'hB3B2B1B0);
        step(1, 1, 8'hC0);
        idle(3);
        step(1, 0, 8'hC1);
        idle(3);
        step(1, 0, 8'hC2);
        do_reset();
        chk("s5_rst_locked", locked, 0);
        chk("s5_rst_data", ch_data, 64'h0);
        step(1, 0, 8'hC3);
        chk("s5_need_sof", locked, 0);

        // Randomized stream: mostly well-formed with injected faults and gaps.
        for (int i = 0; i < 2000; i++) begin
            bit v, sof;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                sof = $urandom_range(0, 1);
            else
                sof = (m_slot == 0);
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step(v, sof, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
